// File: rtl/universal_shift_reg.sv
// ---------------------------------------------------------------------------
// universal_shift_reg
//   Parametrised universal shift register with single-step and burst modes.
//   Supports hold, shift right/left with serial inputs, parallel load, rotate
//   right/left, arithmetic shift right and clear. A burst engine
//   (IDLE -> RUN -> DONE) repeats one latched operation for a step count and
//   reports progress through busy/done.
//
//   Optional feature macro: USR_PARITY_EN (registered even-parity output).
//   Without it, parity is tied low and no parity logic exists.
//
// Ports
//   clk_2      : clock, all state updates on the rising edge
//   reset      : synchronous, active-high; clears all state
//   mode       : operation select (000 hold, 001 SHR, 010 SHL, 011 load,
//                100 ROR, 101 ROL, 110 ASR, 111 clear)
//   ser_in_r   : serial bit entering the MSB on a right shift
//   ser_in_l   : serial bit entering the LSB on a left shift
//   par_in     : parallel load data
//   en         : single-step strobe, honoured only in IDLE
//   start      : burst launch strobe, honoured only in IDLE (wins over en)
//   amount     : burst step count, saturated to NBITS
//   q          : register contents
//   ser_out_r  : q[0]
//   ser_out_l  : q[NBITS-1]
//   busy       : high while the burst engine is in RUN
//   done       : one-cycle pulse when a burst completes
//   parity     : ^q when USR_PARITY_EN is defined, else 0
// ---------------------------------------------------------------------------
module universal_shift_reg #(
   parameter int NBITS = 8,
   parameter int AMT_W = $clog2(NBITS + 1)
) (
   input  logic             clk_2,
   input  logic             reset,
   input  logic [2:0]       mode,
   input  logic             ser_in_r,
   input  logic             ser_in_l,
   input  logic [NBITS-1:0] par_in,
   input  logic             en,
   input  logic             start,
   input  logic [AMT_W-1:0] amount,
   output logic [NBITS-1:0] q,
   output logic             ser_out_r,
   output logic             ser_out_l,
   output logic             busy,
   output logic             done,
   output logic             parity
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   localparam logic [AMT_W-1:0] NBITS_AMT = AMT_W'(NBITS);
   localparam logic [AMT_W-1:0] ONE_AMT   = AMT_W'(1);

   state_t             state_reg, state_next;
   logic [2:0]         op_reg, op_next;
   logic [AMT_W-1:0]   cnt_reg, cnt_next;
   logic [NBITS-1:0]   q_reg, q_next;

   logic [2:0]         op_sel;
   logic               top_in;
   logic               bot_in;
   logic [NBITS-1:0]   q_dn;
   logic [NBITS-1:0]   q_up;
   logic [NBITS-1:0]   stepped_q;
   logic [AMT_W-1:0]   amt_sat;
   logic               single_shot;

   // In RUN the latched burst op drives the datapath; otherwise the live mode.
   assign op_sel = (state_reg == ST_RUN) ? op_reg : mode;

   // Bit shifted into the MSB on any right-moving op (SHR, ROR, ASR).
   always_comb begin
      top_in = q_reg[NBITS-1];
      case (op_sel)
         3'b001:  top_in = ser_in_r;
         3'b100:  top_in = q_reg[0];
         default: top_in = q_reg[NBITS-1];
      endcase
   end

   // Bit shifted into the LSB on any left-moving op (SHL, ROL).
   always_comb begin
      bot_in = q_reg[NBITS-1];
      if (op_sel == 3'b010) begin
         bot_in = ser_in_l;
      end
   end

   // One-position moved copies of q with the injected end bits spliced in.
   genvar gi;
   generate
      for (gi = 0; gi < NBITS; gi++) begin : g_shift
         if (gi == NBITS - 1) begin : g_top
            assign q_dn[gi] = top_in;
         end else begin : g_mid_dn
            assign q_dn[gi] = q_reg[gi+1];
         end
         if (gi == 0) begin : g_bot
            assign q_up[gi] = bot_in;
         end else begin : g_mid_up
            assign q_up[gi] = q_reg[gi-1];
         end
      end
   endgenerate

   always_comb begin
      stepped_q = q_reg;
      case (op_sel)
         3'b000:                 stepped_q = q_reg;
         3'b001, 3'b100, 3'b110: stepped_q = q_dn;
         3'b010, 3'b101:         stepped_q = q_up;
         3'b011:                 stepped_q = par_in;
         3'b111:                 stepped_q = '0;
         default:                stepped_q = q_reg;
      endcase
   end

   assign amt_sat     = (amount > NBITS_AMT) ? NBITS_AMT : amount;
   // Hold, load and clear give the same result however often they repeat,
   // so a burst of them finishes after a single step.
   assign single_shot = (op_reg == 3'b000) || (op_reg == 3'b011) ||
                        (op_reg == 3'b111);

   always_comb begin
      state_next = state_reg;
      op_next    = op_reg;
      cnt_next   = cnt_reg;
      q_next     = q_reg;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               op_next    = mode;
               cnt_next   = amt_sat;
               state_next = (amount == '0) ? ST_DONE : ST_RUN;
            end else if (en) begin
               q_next = stepped_q;
            end
         end
         ST_RUN: begin
            q_next = stepped_q;
            if ((cnt_reg == ONE_AMT) || single_shot) begin
               cnt_next   = '0;
               state_next = ST_DONE;
            end else begin
               cnt_next = cnt_reg - ONE_AMT;
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_2) begin
      if (reset) begin
         state_reg <= ST_IDLE;
         op_reg    <= 3'b000;
         cnt_reg   <= '0;
         q_reg     <= '0;
      end else begin
         state_reg <= state_next;
         op_reg    <= op_next;
         cnt_reg   <= cnt_next;
         q_reg     <= q_next;
      end
   end

   assign q         = q_reg;
   assign ser_out_r = q_reg[0];
   assign ser_out_l = q_reg[NBITS-1];
   assign busy      = (state_reg == ST_RUN);
   assign done      = (state_reg == ST_DONE);

`ifdef USR_PARITY_EN
   // Computed from the next value so parity changes in the same cycle as q.
   logic parity_reg;
   always_ff @(posedge clk_2) begin
      if (reset) begin
         parity_reg <= 1'b0;
      end else begin
         parity_reg <= ^q_next;
      end
   end
   assign parity = parity_reg;
`else
   assign parity = 1'b0;
`endif

endmodule

// File: tb/tb_universal_shift_reg.sv
module tb_universal_shift_reg;

   localparam int NBITS = 8;
   localparam int AMT_W = $clog2(NBITS + 1);

   logic             clk_2 = 1'b0;
   logic             reset;
   logic [2:0]       mode;
   logic             ser_in_r;
   logic             ser_in_l;
   logic [NBITS-1:0] par_in;
   logic             en;
   logic             start;
   logic [AMT_W-1:0] amount;
   logic [NBITS-1:0] q;
   logic             ser_out_r;
   logic             ser_out_l;
   logic             busy;
   logic             done;
   logic             parity;

   universal_shift_reg #(.NBITS(NBITS), .AMT_W(AMT_W)) dut (
      .clk_2     (clk_2),
      .reset     (reset),
      .mode      (mode),
      .ser_in_r  (ser_in_r),
      .ser_in_l  (ser_in_l),
      .par_in    (par_in),
      .en        (en),
      .start     (start),
      .amount    (amount),
      .q         (q),
      .ser_out_r (ser_out_r),
      .ser_out_l (ser_out_l),
      .busy      (busy),
      .done      (done),
      .parity    (parity)
   );

   always #5 clk_2 = ~clk_2;

   typedef struct {
      int         cyc;
      logic [7:0] q;
      logic       busy;
      logic       done;
      string      name;
   } exp_t;

   exp_t sb[$];
   int   cyc      = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   always @(posedge clk_2) cyc <= cyc + 1;

   function automatic logic exp_par(input logic [7:0] v);
`ifdef USR_PARITY_EN
      return ^v;
`else
      return 1'b0 & v[0];
`endif
   endfunction

   // Monitor: every expectation is tagged with the cycle it belongs to.
   always @(negedge clk_2) begin
      exp_t e;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         n_checks++;
         if (e.cyc != cyc || q !== e.q || busy !== e.busy || done !== e.done ||
             ser_out_r !== e.q[0] || ser_out_l !== e.q[7] ||
             parity !== exp_par(e.q)) begin
            n_errors++;
            $display("FAIL %s: cyc=%0d q=%h busy=%b done=%b sr=%b sl=%b par=%b | required cyc=%0d q=%h busy=%b done=%b par=%b",
                     e.name, cyc, q, busy, done, ser_out_r, ser_out_l, parity,
                     e.cyc, e.q, e.busy, e.done, exp_par(e.q));
         end else begin
            $display("check %s: cyc=%0d q=%h busy=%b done=%b par=%b ok",
                     e.name, cyc, q, busy, done, parity);
         end
      end
   end

   // Push the expectation for the cycle after the next edge, then take that edge.
   task automatic step(input string name, input logic [7:0] eq,
                       input logic eb, input logic ed);
      exp_t r;
      r.cyc  = cyc + 1;
      r.q    = eq;
      r.busy = eb;
      r.done = ed;
      r.name = name;
      sb.push_back(r);
      @(posedge clk_2);
      #1;
   endtask

   task automatic idle_inputs();
      en    = 1'b0;
      start = 1'b0;
   endtask

   task automatic load(input logic [7:0] v, input string name);
      mode = 3'b011; par_in = v; en = 1'b1; start = 1'b0;
      step(name, v, 1'b0, 1'b0);
      idle_inputs();
   endtask

   logic [7:0] asr_tab [7];
   logic [7:0] rol_tab [7];

   initial begin
      int k;
      asr_tab = '{8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};
      rol_tab = '{8'h1E, 8'h3C, 8'h78, 8'hF0, 8'hE1, 8'hC3, 8'h87};

      reset = 1'b1; mode = 3'b000; ser_in_r = 1'b0; ser_in_l = 1'b0;
      par_in = 8'h00; en = 1'b0; start = 1'b0; amount = '0;

      // Reset held three cycles
      step("rst0", 8'h00, 1'b0, 1'b0);
      step("rst1", 8'h00, 1'b0, 1'b0);
      step("rst2", 8'h00, 1'b0, 1'b0);
      reset = 1'b0;

      // Single steps
      load(8'hA5, "load_a5");
      mode = 3'b001; ser_in_r = 1'b1; en = 1'b1;
      step("shr_1", 8'hD2, 1'b0, 1'b0);
      idle_inputs(); mode = 3'b111;
      step("en_low_hold", 8'hD2, 1'b0, 1'b0);
      mode = 3'b010; ser_in_l = 1'b0; en = 1'b1;
      step("shl_0", 8'hA4, 1'b0, 1'b0);
      mode = 3'b110;
      step("asr_1", 8'hD2, 1'b0, 1'b0);
      mode = 3'b111;
      step("clear", 8'h00, 1'b0, 1'b0);
      idle_inputs();

      // ROR burst of 3 from 8'h81
      load(8'h81, "load_81");
      mode = 3'b100; start = 1'b1; amount = AMT_W'(3);
      step("ror_launch", 8'h81, 1'b1, 1'b0);
      idle_inputs();
      step("ror_s1", 8'hC0, 1'b1, 1'b0);
      step("ror_s2", 8'h60, 1'b1, 1'b0);
      step("ror_done", 8'h30, 1'b0, 1'b1);
      step("ror_idle", 8'h30, 1'b0, 1'b0);

      // ASR burst with amount 9 saturating to 8
      load(8'h80, "load_80");
      mode = 3'b110; start = 1'b1; amount = AMT_W'(9);
      step("asr_launch", 8'h80, 1'b1, 1'b0);
      idle_inputs();
      for (int i = 0; i < 7; i++) step($sformatf("asr_s%0d", i + 1), asr_tab[i], 1'b1, 1'b0);
      step("asr_done", 8'hFF, 1'b0, 1'b1);
      step("asr_idle", 8'hFF, 1'b0, 1'b0);

      // Zero-length burst
      mode = 3'b001; ser_in_r = 1'b0; start = 1'b1; amount = '0;
      step("amt0_done", 8'hFF, 1'b0, 1'b1);
      idle_inputs();
      step("amt0_idle", 8'hFF, 1'b0, 1'b0);

      // start+en together, then inputs churn during RUN and DONE
      mode = 3'b001; ser_in_r = 1'b0; start = 1'b1; en = 1'b1; amount = AMT_W'(2);
      step("se_launch", 8'hFF, 1'b1, 1'b0);
      mode = 3'b000; amount = AMT_W'(8);
      step("run_ignore", 8'h7F, 1'b1, 1'b0);
      step("run_done", 8'h3F, 1'b0, 1'b1);
      mode = 3'b111;
      step("done_ignore", 8'h3F, 1'b0, 1'b0);
      idle_inputs();
      step("after_done", 8'h3F, 1'b0, 1'b0);

      // ROL full rotation is lossless
      load(8'h0F, "load_0f");
      mode = 3'b101; start = 1'b1; amount = AMT_W'(8);
      step("rol_launch", 8'h0F, 1'b1, 1'b0);
      idle_inputs();
      for (int i = 0; i < 7; i++) step($sformatf("rol_s%0d", i + 1), rol_tab[i], 1'b1, 1'b0);
      step("rol_done", 8'h0F, 1'b0, 1'b1);
      step("rol_idle", 8'h0F, 1'b0, 1'b0);

      // Odd-parity value, then reset in the middle of a burst
      load(8'h07, "load_07");
      mode = 3'b100; start = 1'b1; amount = AMT_W'(5);
      step("abort_launch", 8'h07, 1'b1, 1'b0);
      idle_inputs();
      step("abort_s1", 8'h83, 1'b1, 1'b0);
      reset = 1'b1;
      step("abort_rst", 8'h00, 1'b0, 1'b0);
      reset = 1'b0;
      step("abort_post1", 8'h00, 1'b0, 1'b0);
      step("abort_post2", 8'h00, 1'b0, 1'b0);

      // Drain the scoreboard with a bounded wait
      k = 0;
      while (sb.size() > 0 && k < 10) begin
         @(posedge clk_2);
         k++;
      end
      @(posedge clk_2);
      if (sb.size() > 0) begin
         n_errors++;
         $display("FAIL drain: %0d expectations left, required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time %0t reached, required finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
